// File: rtl/bridge_tx_arbiter_pkg.sv
// Shared constants and types for the bridge transmit arbiter.
package bridge_tx_arbiter_pkg;

    // Traffic class / source index
    localparam int NUM_SRC = 3;
    localparam int CLS_P   = 0;
    localparam int CLS_NP  = 1;
    localparam int CLS_CPL = 2;

    // Tx_FC bit positions
    localparam int FC_PH   = 0;
    localparam int FC_PD   = 1;
    localparam int FC_NPH  = 2;
    localparam int FC_NPD  = 3;
    localparam int FC_CPLH = 4;
    localparam int FC_CPLD = 5;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // A class may be granted only when both its header and data credits are present.
    function automatic logic [NUM_SRC-1:0] fc_ok(input logic [5:0] fc);
        logic [NUM_SRC-1:0] r;
        r[CLS_P]   = fc[FC_PH]   & fc[FC_PD];
        r[CLS_NP]  = fc[FC_NPH]  & fc[FC_NPD];
        r[CLS_CPL] = fc[FC_CPLH] & fc[FC_CPLD];
        return r;
    endfunction

endpackage

// File: rtl/bridge_rr_arb3.sv
// Combinational 3-way round-robin picker: first requester after ptr wins.
module bridge_rr_arb3
    import bridge_tx_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [1:0]         gnt_idx,
    output logic               found
);

    // Scan ptr+1, ptr+2, ptr+3 (mod 3); the previous winner is searched last.
    always_comb begin
        int c;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            c = (int'(ptr) + k) % NUM_SRC;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = 2'(c);
            end
        end
    end

endmodule

// File: rtl/bridge_tx_arbiter.sv
// Transmit arbiter: round-robin over posted / non-posted / completion sources,
// credit-gated at grant time, packet-locked grant, single registered output stage.
module bridge_tx_arbiter
    import bridge_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic                      Tx_CLK,
    input  logic                      Tx_RST,
    input  logic                      Tx_Link_En,
    input  logic [5:0]                Tx_FC,
    input  logic [NUM_SRC-1:0]        Src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] Src_data,
    input  logic [NUM_SRC*KEEP_W-1:0] Src_keep,
    input  logic [NUM_SRC-1:0]        Src_last,
    output logic [NUM_SRC-1:0]        Src_ready,
    output logic [DATA_W-1:0]         Tx_tdata,
    output logic [KEEP_W-1:0]         Tx_tkeep,
    output logic                      Tx_tlast,
    output logic                      Tx_tvalid,
    input  logic                      Tx_tready,
    output logic                      Tx_busy,
    output logic [NUM_SRC*CNT_W-1:0]  Tx_pkt_cnt
);

    state_e                         state_q, state_d;
    logic [NUM_SRC-1:0]             gnt_q, gnt_d;
    logic [1:0]                     ptr_q, ptr_d;
    logic [NUM_SRC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]              tdata_q, tdata_d;
    logic [KEEP_W-1:0]              tkeep_q, tkeep_d;
    logic                           tlast_q, tlast_d;
    logic                           tvalid_q, tvalid_d;

    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [1:0]         arb_idx;
    logic               arb_found;
    logic               out_free;
    logic               beat_acc;
    logic [DATA_W-1:0]  sel_data;
    logic [KEEP_W-1:0]  sel_keep;
    logic               sel_last;

    // Credits and link enable only matter here, at arbitration time.
    assign elig = Src_valid & fc_ok(Tx_FC) & {NUM_SRC{Tx_Link_En}};

    bridge_rr_arb3 u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .found   (arb_found)
    );

    // Output register can take a beat if empty or draining this cycle.
    assign out_free  = !tvalid_q | Tx_tready;
    assign Src_ready = (state_q == XFER) ? (gnt_q & {NUM_SRC{out_free}}) : '0;
    assign beat_acc  = |(Src_valid & Src_ready);

    // One-hot AND-OR mux of the granted source's beat.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q[i]) begin
                sel_data = sel_data | Src_data[i*DATA_W +: DATA_W];
                sel_keep = sel_keep | Src_keep[i*KEEP_W +: KEEP_W];
            end
        end
        sel_last = |(Src_last & gnt_q);
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the last beat is accepted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_gnt;
                    ptr_d   = arb_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_acc && sel_last) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (gnt_q[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output stage: load on acceptance, otherwise drop valid once the core takes it.
    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (beat_acc) begin
            tdata_d  = sel_data;
            tkeep_d  = sel_keep;
            tlast_d  = sel_last;
            tvalid_d = 1'b1;
        end else if (Tx_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge Tx_CLK or posedge Tx_RST) begin
        if (Tx_RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= 2'(CLS_CPL);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stream registers.
    always_ff @(posedge Tx_CLK or posedge Tx_RST) begin
        if (Tx_RST) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign Tx_tdata   = tdata_q;
    assign Tx_tkeep   = tkeep_q;
    assign Tx_tlast   = tlast_q;
    assign Tx_tvalid  = tvalid_q;
    assign Tx_busy    = (state_q == XFER);
    assign Tx_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_bridge_tx_arbiter.sv
// Self-checking bench for bridge_tx_arbiter: grant vectors, directed sequences,
// and randomized traffic against a packet-level round-robin model.
module tb_bridge_tx_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 16;

    logic            Tx_CLK = 1'b0;
    logic            Tx_RST;
    logic            Tx_Link_En;
    logic [5:0]      Tx_FC;
    logic [2:0]      Src_valid;
    logic [3*DW-1:0] Src_data;
    logic [3*KW-1:0] Src_keep;
    logic [2:0]      Src_last;
    logic [2:0]      Src_ready;
    logic [DW-1:0]   Tx_tdata;
    logic [KW-1:0]   Tx_tkeep;
    logic            Tx_tlast;
    logic            Tx_tvalid;
    logic            Tx_tready;
    logic            Tx_busy;
    logic [3*CW-1:0] Tx_pkt_cnt;

    bridge_tx_arbiter #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .Tx_CLK(Tx_CLK), .Tx_RST(Tx_RST), .Tx_Link_En(Tx_Link_En), .Tx_FC(Tx_FC),
        .Src_valid(Src_valid), .Src_data(Src_data), .Src_keep(Src_keep),
        .Src_last(Src_last), .Src_ready(Src_ready), .Tx_tdata(Tx_tdata),
        .Tx_tkeep(Tx_tkeep), .Tx_tlast(Tx_tlast), .Tx_tvalid(Tx_tvalid),
        .Tx_tready(Tx_tready), .Tx_busy(Tx_busy), .Tx_pkt_cnt(Tx_pkt_cnt)
    );

    always #5 Tx_CLK = ~Tx_CLK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic       link;
        logic [5:0] fc;
        logic [2:0] valid;
        logic       exp_busy;
        logic [2:0] exp_ready;
    } vec_t;

    beat_t srcq[3][$];
    beat_t obs[$];
    int    obs_cyc[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    rdy_pct = 100;
    int    stall_from = -1;
    int    stall_len = 0;
    int    fc_drop_at = -1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        return b;
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return Tx_pkt_cnt[i*CW +: CW];
    endfunction

    task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++)
            srcq[src].push_back(mk(base + DW'(b), KW'(8'hFF >> (b % 8)), (b == len - 1)));
    endtask

    task automatic do_reset();
        Tx_RST = 1'b1;
        Tx_Link_En = 1'b1;
        Tx_FC = 6'h3F;
        Src_valid = '0;
        Src_data = '0;
        Src_keep = '0;
        Src_last = '0;
        Tx_tready = 1'b0;
        rdy_pct = 100; stall_from = -1; stall_len = 0; fc_drop_at = -1;
        for (int i = 0; i < 3; i++) srcq[i].delete();
        obs.delete();
        obs_cyc.delete();
        repeat (2) @(posedge Tx_CLK);
        #3 Tx_RST = 1'b0;
        @(negedge Tx_CLK);
    endtask

    // Drives sources from their queues, collects output beats, checks hold/stall rules.
    task automatic run(input int target, input int budget);
        int    c;
        logic  prev_stall;
        beat_t prev_b, cur;
        c = 0;
        prev_stall = 1'b0;
        prev_b = '0;
        while (obs.size() < target && c < budget) begin
            @(posedge Tx_CLK);
            #1;
            if (c == fc_drop_at) Tx_FC = '0;
            for (int i = 0; i < 3; i++) begin
                Src_valid[i] = (srcq[i].size() > 0);
                if (srcq[i].size() > 0) begin
                    Src_data[i*DW +: DW] = srcq[i][0].d;
                    Src_keep[i*KW +: KW] = srcq[i][0].k;
                    Src_last[i]          = srcq[i][0].l;
                end
            end
            if (c >= stall_from && c < stall_from + stall_len) Tx_tready = 1'b0;
            else Tx_tready = ($urandom_range(99) < rdy_pct);
            @(negedge Tx_CLK);
            cur = mk(Tx_tdata, Tx_tkeep, Tx_tlast);
            if (prev_stall) begin
                chk("hold_valid", Tx_tvalid, 1);
                chk("hold_beat", cur, prev_b);
            end
            if (Tx_tvalid && !Tx_tready) chk("stall_src_ready", Src_ready, 0);
            chk("ready_onehot", ($countones(Src_ready) <= 1), 1);
            prev_stall = Tx_tvalid & !Tx_tready;
            prev_b = cur;
            for (int i = 0; i < 3; i++)
                if (Src_valid[i] && Src_ready[i]) void'(srcq[i].pop_front());
            if (Tx_tvalid && Tx_tready) begin
                obs.push_back(cur);
                obs_cyc.push_back(c);
            end
            c++;
        end
        if (obs.size() < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got %0d beats, expected %0d", obs.size(), target);
        end
        @(posedge Tx_CLK);
        #1 Src_valid = '0;
        for (int i = 0; i < 3; i++) if (srcq[i].size() > 0) Src_valid[i] = 1'b1;
        @(negedge Tx_CLK);
    endtask

    vec_t vecs[10];

    initial begin
        beat_t ref_b[$];
        beat_t mq[3][$];
        beat_t exp_q[$];
        int    npk[3];
        int    total, ptr, k_i;

        vecs[0] = '{1'b1, 6'h3F,      3'b001, 1'b1, 3'b001};
        vecs[1] = '{1'b1, 6'h3F,      3'b111, 1'b1, 3'b001};
        vecs[2] = '{1'b1, 6'b110011,  3'b110, 1'b1, 3'b100};
        vecs[3] = '{1'b0, 6'h3F,      3'b111, 1'b0, 3'b000};
        vecs[4] = '{1'b1, 6'b000000,  3'b111, 1'b0, 3'b000};
        vecs[5] = '{1'b1, 6'b001111,  3'b110, 1'b1, 3'b010};
        vecs[6] = '{1'b1, 6'b111101,  3'b011, 1'b1, 3'b010};
        vecs[7] = '{1'b1, 6'b010101,  3'b111, 1'b0, 3'b000};
        vecs[8] = '{1'b1, 6'h3F,      3'b000, 1'b0, 3'b000};
        vecs[9] = '{1'b1, 6'h3F,      3'b100, 1'b1, 3'b100};

        // Reset state
        do_reset();
        chk("rst_tvalid", Tx_tvalid, 0);
        chk("rst_tlast", Tx_tlast, 0);
        chk("rst_tdata", Tx_tdata, 0);
        chk("rst_tkeep", Tx_tkeep, 0);
        chk("rst_busy", Tx_busy, 0);
        chk("rst_ready", Src_ready, 0);
        chk("rst_cnt", Tx_pkt_cnt, 0);

        // Grant-decision vectors from a fresh reset (posted has priority first)
        for (int v = 0; v < 10; v++) begin
            do_reset();
            Tx_Link_En = vecs[v].link;
            Tx_FC      = vecs[v].fc;
            Src_valid  = vecs[v].valid;
            Src_last   = 3'b111;
            Tx_tready  = 1'b1;
            @(posedge Tx_CLK);
            #1;
            chk($sformatf("vec%0d_busy", v), Tx_busy, vecs[v].exp_busy);
            chk($sformatf("vec%0d_ready", v), Src_ready, vecs[v].exp_ready);
            chk($sformatf("vec%0d_tvalid", v), Tx_tvalid, 0);
        end

        // Posted 3-beat packet, core always ready
        do_reset();
        push_pkt(0, 3, 64'h1000);
        ref_b = srcq[0];
        run(3, 30);
        chk("p3_beats", obs.size(), 3);
        for (int j = 0; j < obs.size() && j < 3; j++) chk($sformatf("p3_beat%0d", j), obs[j], ref_b[j]);
        if (obs_cyc.size() > 0) chk("p3_first_cycle", obs_cyc[0], 2);
        chk("p3_cnt_p", cnt_of(0), 1);

        // Round robin, 1-beat packets from all sources
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) push_pkt(s, 1, DW'(s * 16 + r));
        run(6, 40);
        chk("rr_count", obs.size(), 6);
        for (int j = 0; j < obs.size() && j < 6; j++) begin
            chk($sformatf("rr_order%0d", j), obs[j].d, DW'((j % 3) * 16 + j / 3));
            if (j > 0) chk($sformatf("rr_gap%0d", j), obs_cyc[j] - obs_cyc[j-1], 2);
        end
        chk("rr_cnt", Tx_pkt_cnt, {16'd2, 16'd2, 16'd2});

        // Non-posted credits missing: only completions go; then NP on credit return
        do_reset();
        Tx_FC = 6'b110011;
        push_pkt(1, 1, 64'hAA00);
        for (int r = 0; r < 3; r++) push_pkt(2, 1, DW'(64'hCC00 + r));
        run(3, 40);
        for (int j = 0; j < obs.size() && j < 3; j++) chk($sformatf("fcnp_cpl%0d", j), obs[j].d, DW'(64'hCC00 + j));
        chk("fcnp_np_pending", srcq[1].size(), 1);
        chk("fcnp_np_cnt", cnt_of(1), 0);
        Tx_FC = 6'h3F;
        run(4, 20);
        if (obs.size() >= 4) chk("fcnp_np_granted", obs[3].d, 64'hAA00);
        chk("fcnp_cnt", Tx_pkt_cnt, {16'd3, 16'd1, 16'd0});

        // Backpressure: 3-cycle stall at beat 2 of a 4-beat posted packet
        do_reset();
        push_pkt(0, 4, 64'h2000);
        ref_b = srcq[0];
        stall_from = 3; stall_len = 3;
        run(4, 40);
        chk("stall_beats", obs.size(), 4);
        for (int j = 0; j < obs.size() && j < 4; j++) chk($sformatf("stall_beat%0d", j), obs[j], ref_b[j]);
        if (obs_cyc.size() > 1) chk("stall_resume_cycle", obs_cyc[1], 6);

        // Credits removed after grant: packet still completes
        do_reset();
        push_pkt(0, 4, 64'h3000);
        ref_b = srcq[0];
        fc_drop_at = 2;
        run(4, 40);
        chk("fcdrop_beats", obs.size(), 4);
        if (obs.size() >= 4) chk("fcdrop_last", obs[3], ref_b[3]);
        chk("fcdrop_cnt", cnt_of(0), 1);

        // Link disabled with requests pending: no grant
        do_reset();
        Tx_Link_En = 1'b0;
        Src_valid  = 3'b111;
        Src_last   = 3'b111;
        Tx_tready  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge Tx_CLK);
            chk($sformatf("linkdown_busy%0d", j), Tx_busy, 0);
            chk($sformatf("linkdown_ready%0d", j), Src_ready, 0);
        end

        // Asynchronous reset in the middle of a packet
        do_reset();
        push_pkt(0, 4, 64'h4000);
        run(2, 20);
        #2 Tx_RST = 1'b1;
        #1;
        chk("midrst_tvalid", Tx_tvalid, 0);
        chk("midrst_tlast", Tx_tlast, 0);
        chk("midrst_tdata", Tx_tdata, 0);
        chk("midrst_tkeep", Tx_tkeep, 0);
        chk("midrst_busy", Tx_busy, 0);
        chk("midrst_ready", Src_ready, 0);
        chk("midrst_cnt", Tx_pkt_cnt, 0);
        Src_valid = '0;
        @(negedge Tx_CLK);
        Tx_RST = 1'b0;

        // Randomized traffic against a packet-level round-robin model
        for (int round = 0; round < 3; round++) begin
            do_reset();
            total = 0;
            for (int s = 0; s < 3; s++) begin
                npk[s] = $urandom_range(2, 5);
                for (int p = 0; p < npk[s]; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        srcq[s].push_back(mk({$urandom, $urandom}, KW'($urandom), (b == len - 1)));
                    total += len;
                end
                mq[s] = srcq[s];
            end
            // Model: every non-empty source stays requesting, so packets interleave
            // strictly in round-robin order starting after completion (index 2).
            exp_q.delete();
            ptr = 2;
            while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
                for (int k = 1; k <= 3; k++) begin
                    k_i = (ptr + k) % 3;
                    if (mq[k_i].size() > 0) break;
                end
                ptr = k_i;
                while (mq[k_i].size() > 0) begin
                    beat_t b;
                    b = mq[k_i].pop_front();
                    exp_q.push_back(b);
                    if (b.l) break;
                end
            end
            rdy_pct = $urandom_range(30, 90);
            run(total, 3000);
            chk($sformatf("rnd%0d_beats", round), obs.size(), exp_q.size());
            for (int j = 0; j < obs.size() && j < exp_q.size(); j++)
                chk($sformatf("rnd%0d_beat%0d", round, j), obs[j], exp_q[j]);
            for (int s = 0; s < 3; s++)
                chk($sformatf("rnd%0d_cnt%0d", round, s), cnt_of(s), CW'(npk[s]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
